// File: rtl/hsv_duty_seq_if.sv
// -----------------------------------------------------------------------------
// hsv_duty_seq_if
// Handshake/result bundle for the hue-to-PWM-duty converter.
//   Hue input side    : in_valid, in_ready, in_hue[8:0]
//   Result output side: out_valid, out_ready, out_r/g/b[7:0],
//                       out_duty_r/g/b[DUTY_W-1:0]
// Modports:
//   master - the producer of hues / consumer of results (e.g. the LED top)
//   slave  - the converter itself
// -----------------------------------------------------------------------------
interface hsv_duty_seq_if #(
    parameter int DUTY_W = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        in_hue;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_r;
    logic [7:0]        out_g;
    logic [7:0]        out_b;
    logic [DUTY_W-1:0] out_duty_r;
    logic [DUTY_W-1:0] out_duty_g;
    logic [DUTY_W-1:0] out_duty_b;

    modport master (
        output in_valid, in_hue, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b,
               out_duty_r, out_duty_g, out_duty_b
    );

    modport slave (
        input  in_valid, in_hue, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b,
               out_duty_r, out_duty_g, out_duty_b
    );
endinterface

// File: rtl/hsv_duty_seq.sv
// -----------------------------------------------------------------------------
// hsv_duty_seq
// Sequential hue (0-359, larger values wrapped by -360) to full-saturation RGB
// and PWM duty converter. A single restoring divider (one quotient bit per
// cycle) is time-shared between the ramp computation and the duty scaling.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - hsv_duty_seq_if.slave (hue handshake in, RGB/duty result out)
// Build option:
//   GAMMA_EN - when defined, duty = floor(C*C*PWM_INTERVAL/65025) (quadratic
//              gamma, 27-cycle channel divide at default); otherwise
//              duty = floor(C*PWM_INTERVAL/255). RGB outputs stay linear.
// Latency (accept edge to out_valid): 1 + 28 + 3*SCALE_NW edges.
// -----------------------------------------------------------------------------
module hsv_duty_seq #(
    parameter int PWM_INTERVAL = 1200,
    parameter int DUTY_W       = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    hsv_duty_seq_if.slave bus
);
`ifdef GAMMA_EN
    localparam int SCALE_DEN = 65025;
`else
    localparam int SCALE_DEN = 255;
`endif
    // Numerator widths set the cycle count of each divide.
    localparam int SCALE_NW = $clog2(SCALE_DEN * PWM_INTERVAL + 1);
    localparam int RAMP_NW  = 14;                      // 60*255 < 2^14
    localparam int DIV_W    = (SCALE_NW > RAMP_NW) ? SCALE_NW : RAMP_NW;
    localparam int DVS_W    = $clog2(SCALE_DEN + 1);   // also covers 60
    localparam int REM_W    = DVS_W + 1;
    localparam int CNT_W    = $clog2(DIV_W);

    typedef enum logic [2:0] {
        S_IDLE, S_SECTOR, S_RAMP_DIV, S_SCALE_DIV, S_DONE
    } state_t;

    state_t             r_state, w_state_next;
    logic [8:0]         r_hue;
    logic [2:0]         r_sector;
    logic [5:0]         r_frac;
    logic [7:0]         r_up, r_dn;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_phase;
    logic [DIV_W-1:0]   r_num;
    logic [DVS_W-1:0]   r_rem;
    logic [DUTY_W-1:0]  r_duty [2];
    logic [7:0]         r_out_c [3];
    logic [DUTY_W-1:0]  r_out_duty [3];

    logic               w_accept, w_is_ramp, w_last, w_div_first, w_fits;
    logic [8:0]         w_hue_wrap, w_base;
    logic [2:0]         w_sector;
    logic [5:0]         w_frac;
    logic [7:0]         w_chan [3];
    logic [7:0]         w_chan_sel;
    logic [DIV_W-1:0]   w_load, w_num_src, w_num_new;
    logic [REM_W-1:0]   w_divisor, w_trial;
    logic [DVS_W-1:0]   w_rem_src, w_rem_new;

    // Handshake depends on state and out_ready only, never on in_valid.
    assign bus.in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (r_state == S_DONE);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_hue_wrap    = (bus.in_hue >= 9'd360) ? bus.in_hue - 9'd360 : bus.in_hue;

    assign bus.out_r      = r_out_c[0];
    assign bus.out_g      = r_out_c[1];
    assign bus.out_b      = r_out_c[2];
    assign bus.out_duty_r = r_out_duty[0];
    assign bus.out_duty_g = r_out_duty[1];
    assign bus.out_duty_b = r_out_duty[2];

    // Sector by compare chain instead of a divide-by-60.
    always_comb begin
        w_sector = 3'd5;
        w_base   = 9'd300;
        if (r_hue < 9'd60)       begin w_sector = 3'd0; w_base = 9'd0;   end
        else if (r_hue < 9'd120) begin w_sector = 3'd1; w_base = 9'd60;  end
        else if (r_hue < 9'd180) begin w_sector = 3'd2; w_base = 9'd120; end
        else if (r_hue < 9'd240) begin w_sector = 3'd3; w_base = 9'd180; end
        else if (r_hue < 9'd300) begin w_sector = 3'd4; w_base = 9'd240; end
    end
    assign w_frac = 6'(r_hue - w_base);

    // Channel values from sector and the two ramps.
    always_comb begin
        w_chan[0] = 8'd0;
        w_chan[1] = 8'd0;
        w_chan[2] = 8'd0;
        case (r_sector)
            3'd0:    begin w_chan[0] = 8'd255; w_chan[1] = r_up;   end
            3'd1:    begin w_chan[0] = r_dn;   w_chan[1] = 8'd255; end
            3'd2:    begin w_chan[1] = 8'd255; w_chan[2] = r_up;   end
            3'd3:    begin w_chan[1] = r_dn;   w_chan[2] = 8'd255; end
            3'd4:    begin w_chan[0] = r_up;   w_chan[2] = 8'd255; end
            default: begin w_chan[0] = 8'd255; w_chan[2] = r_dn;   end
        endcase
    end

    always_comb begin
        case (r_phase)
            2'd0:    w_chan_sel = w_chan[0];
            2'd1:    w_chan_sel = w_chan[1];
            default: w_chan_sel = w_chan[2];
        endcase
    end

    // Shared divider. The numerator is left-aligned in r_num; each cycle shifts
    // one numerator bit into the remainder and one quotient bit into the LSB,
    // so after n cycles r_num holds the quotient. On the first cycle of a
    // divide the fresh numerator is used directly, so no separate load cycle.
    assign w_is_ramp   = (r_state == S_RAMP_DIV);
    assign w_div_first = (r_cnt == '0);
    assign w_last      = w_is_ramp ? (r_cnt == CNT_W'(RAMP_NW - 1))
                                   : (r_cnt == CNT_W'(SCALE_NW - 1));

    always_comb begin
        w_load    = '0;
        w_divisor = '0;
        if (w_is_ramp) begin
            w_divisor = REM_W'(60);
            if (r_phase == 2'd0)
                w_load = DIV_W'(r_frac) * DIV_W'(255);
            else
                w_load = (DIV_W'(60) - DIV_W'(r_frac)) * DIV_W'(255);
            w_load = w_load << (DIV_W - RAMP_NW);
        end else begin
            w_divisor = REM_W'(SCALE_DEN);
`ifdef GAMMA_EN
            w_load = DIV_W'(w_chan_sel) * DIV_W'(w_chan_sel) * DIV_W'(PWM_INTERVAL);
`else
            w_load = DIV_W'(w_chan_sel) * DIV_W'(PWM_INTERVAL);
`endif
            w_load = w_load << (DIV_W - SCALE_NW);
        end
    end

    assign w_num_src = w_div_first ? w_load : r_num;
    assign w_rem_src = w_div_first ? '0 : r_rem;
    assign w_trial   = {w_rem_src, w_num_src[DIV_W-1]};
    assign w_fits    = (w_trial >= w_divisor);
    assign w_rem_new = w_fits ? DVS_W'(w_trial - w_divisor) : DVS_W'(w_trial);
    assign w_num_new = {w_num_src[DIV_W-2:0], w_fits};

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_state_next = S_SECTOR;
            S_SECTOR:    w_state_next = S_RAMP_DIV;
            S_RAMP_DIV:  if (w_last && (r_phase == 2'd1)) w_state_next = S_SCALE_DIV;
            S_SCALE_DIV: if (w_last && (r_phase == 2'd2)) w_state_next = S_DONE;
            S_DONE:      if (bus.out_ready) w_state_next = bus.in_valid ? S_SECTOR : S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hue    <= '0;
            r_sector <= '0;
            r_frac   <= '0;
            r_up     <= '0;
            r_dn     <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_num    <= '0;
            r_rem    <= '0;
            r_duty[0] <= '0;
            r_duty[1] <= '0;
            for (int i = 0; i < 3; i++) begin
                r_out_c[i]    <= '0;
                r_out_duty[i] <= '0;
            end
        end else begin
            if (w_accept) r_hue <= w_hue_wrap;
            case (r_state)
                S_SECTOR: begin
                    r_sector <= w_sector;
                    r_frac   <= w_frac;
                    r_cnt    <= '0;
                    r_phase  <= '0;
                end
                S_RAMP_DIV, S_SCALE_DIV: begin
                    r_num <= w_num_new;
                    r_rem <= w_rem_new;
                    if (!w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (w_is_ramp) begin
                            if (r_phase == 2'd0) begin
                                r_up    <= w_num_new[7:0];
                                r_phase <= 2'd1;
                            end else begin
                                r_dn    <= w_num_new[7:0];
                                r_phase <= 2'd0;
                            end
                        end else if (r_phase == 2'd2) begin
                            // Entering DONE: publish all results on one edge.
                            for (int i = 0; i < 3; i++) r_out_c[i] <= w_chan[i];
                            r_out_duty[0] <= r_duty[0];
                            r_out_duty[1] <= r_duty[1];
                            r_out_duty[2] <= w_num_new[DUTY_W-1:0];
                            r_phase       <= 2'd0;
                        end else begin
                            if (r_phase == 2'd0) r_duty[0] <= w_num_new[DUTY_W-1:0];
                            else                 r_duty[1] <= w_num_new[DUTY_W-1:0];
                            r_phase <= r_phase + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hsv_duty_seq.sv
// -----------------------------------------------------------------------------
// tb_hsv_duty_seq
// Directed + randomized bench for hsv_duty_seq. Expected colours and duties
// come from an arithmetic model of the hue rules; latency, stability under
// backpressure, back-to-back accept and mid-conversion reset are checked.
// Honours GAMMA_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_hsv_duty_seq;
    localparam int PWM_INTERVAL = 1200;
    localparam int DUTY_W       = 11;
`ifdef GAMMA_EN
    localparam int LAT = 110;
`else
    localparam int LAT = 86;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hsv_duty_seq_if #(.DUTY_W(DUTY_W)) bus ();

    hsv_duty_seq #(.PWM_INTERVAL(PWM_INTERVAL), .DUTY_W(DUTY_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_o [6];   // model result for the conversion in flight
    int cur_o [6];   // values the DUT outputs must currently hold

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int duty_of(input int c);
`ifdef GAMMA_EN
        return (c * c * PWM_INTERVAL) / 65025;
`else
        return (c * PWM_INTERVAL) / 255;
`endif
    endfunction

    // Hue -> (R,G,B,dutyR,dutyG,dutyB) straight from the colour-wheel rules.
    task automatic model(input int hue_in);
        int h, s, f, up, dn;
        int c [3];
        h = hue_in;
        if (h >= 360) h = h - 360;
        s  = h / 60;
        f  = h - 60 * s;
        up = (f * 255) / 60;
        dn = ((60 - f) * 255) / 60;
        case (s)
            0:       c = '{255, up, 0};
            1:       c = '{dn, 255, 0};
            2:       c = '{0, 255, up};
            3:       c = '{0, dn, 255};
            4:       c = '{up, 0, 255};
            default: c = '{255, 0, dn};
        endcase
        for (int i = 0; i < 3; i++) begin
            exp_o[i]     = c[i];
            exp_o[3 + i] = duty_of(c[i]);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [31:0] o [6];
        o[0] = 32'(bus.out_r);
        o[1] = 32'(bus.out_g);
        o[2] = 32'(bus.out_b);
        o[3] = 32'(bus.out_duty_r);
        o[4] = 32'(bus.out_duty_g);
        o[5] = 32'(bus.out_duty_b);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_o%0d", tag, i), o[i], 32'(cur_o[i]));
    endtask

    // Present a hue for exactly one edge; b2b also raises out_ready so a
    // finished result is taken on the same edge.
    task automatic accept(input int hue, input bit b2b);
        logic [8:0] hv;
        hv = 9'(hue);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_hue   = hv;
        if (b2b) bus.out_ready = 1'b1;
        #1;
        check($sformatf("ready_before_accept_h%0d", hue), 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_hue    = 9'($urandom);
        check($sformatf("valid_after_accept_h%0d", hue), 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_conv(input int hue, input bit b2b);
        int n;
        model(hue);
        accept(hue, b2b);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 40) begin
                check($sformatf("mid_ready_h%0d", hue), 32'(bus.in_ready), 32'd0);
                check_outs($sformatf("mid_hold_h%0d", hue));
            end
        end
        check($sformatf("latency_h%0d", hue), 32'(n), 32'(LAT));
        for (int i = 0; i < 6; i++) cur_o[i] = exp_o[i];
        check_outs($sformatf("result_h%0d", hue));
        check($sformatf("done_ready_h%0d", hue), 32'(bus.in_ready), 32'd0);
        $display("conv hue=%0d rgb=%0d/%0d/%0d duty=%0d/%0d/%0d latency=%0d",
                 hue, bus.out_r, bus.out_g, bus.out_b,
                 bus.out_duty_r, bus.out_duty_g, bus.out_duty_b, n);
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("idle_ready", 32'(bus.in_ready), 32'd1);
        check_outs("idle_hold");
    endtask

    initial begin
        int h;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_hue    = 9'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) cur_o[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_ready", 32'(bus.in_ready), 32'd1);
        check_outs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_ready", 32'(bus.in_ready), 32'd1);

        // Directed hues, including wrap of 400 and the sector edges.
        run_conv(0, 1'b0);   release_out();
        run_conv(30, 1'b0);  release_out();
        run_conv(90, 1'b0);  release_out();
        run_conv(200, 1'b0); release_out();
        run_conv(359, 1'b0); release_out();
        run_conv(400, 1'b0); release_out();
        run_conv(300, 1'b0); release_out();

        // Backpressure: hold 20 cycles in DONE while in_valid wiggles.
        run_conv(int'($urandom_range(0, 511)), 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.in_hue   = 9'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("hold_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold_ready_%0d", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        check_outs("hold");

        // Back-to-back accepts straight out of DONE.
        for (int k = 0; k < 3; k++) begin
            h = int'($urandom_range(0, 511));
            run_conv(h, 1'b1);
        end
        release_out();

        // Random single conversions.
        for (int k = 0; k < 5; k++) begin
            h = int'($urandom_range(0, 511));
            run_conv(h, 1'b0);
            release_out();
        end

        // Reset at cycle 30 of a conversion.
        accept(int'($urandom_range(0, 359)), 1'b0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) cur_o[i] = 0;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd1);
        check_outs("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Recovery after abort.
        run_conv(120, 1'b0);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
